// File: rtl/snake_pkg.sv
// snake_pkg: shared grid constants and target placement FSM states
package snake_pkg;
   localparam int GRID_H    = 160;
   localparam int GRID_V    = 120;
   localparam int COORD_H_W = 8;
   localparam int COORD_V_W = 7;
   localparam int SEG_DEPTH = 32;
   localparam int TRY_LIMIT = 16;
   typedef enum logic [2:0] {
      S_IDLE, S_SAMPLE, S_CHECK, S_SCAN_ADDR, S_SCAN_CMP, S_COMMIT
   } place_state_t;
endpackage

// File: rtl/snake_body_scanner.sv
// snake_body_scanner: walks body RAM segments 0..LEN-1 looking for a hit on the candidate
module snake_body_scanner
   import snake_pkg::*;
#(
   parameter int SEG_AW = 5
)(
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 START,
   input  logic                 CMP,
   input  logic [SEG_AW:0]      LEN,
   input  logic [COORD_H_W-1:0] CAND_H,
   input  logic [COORD_V_W-1:0] CAND_V,
   input  logic [COORD_H_W-1:0] SEG_H,
   input  logic [COORD_V_W-1:0] SEG_V,
   output logic [SEG_AW-1:0]    SEG_ADDR,
   output logic                 HIT,
   output logic                 CLEAR,
   output logic                 DONE
);
   logic last;
   always_comb begin
      last  = {1'b0, SEG_ADDR} == LEN - (SEG_AW+1)'(1);
      HIT   = CMP && SEG_H == CAND_H && SEG_V == CAND_V;
      CLEAR = CMP && !HIT && last;
      DONE  = HIT || CLEAR;
   end
   always_ff @(posedge CLK)
      if (RESET || START) SEG_ADDR <= '0;
      else if (CMP && !DONE) SEG_ADDR <= SEG_ADDR + SEG_AW'(1);
endmodule

// File: rtl/target_placement_ctrl.sv
// target_placement_ctrl: places the food target by rejection sampling against grid bounds
// and the snake body, then commits it for rendering and collision logic.
module target_placement_ctrl
   import snake_pkg::*;
#(
   parameter int H_MAX        = GRID_H,
   parameter int V_MAX        = GRID_V,
   parameter int MAX_SEGMENTS = SEG_DEPTH,
   parameter int MAX_TRIES    = TRY_LIMIT,
   parameter int SEG_AW       = $clog2(MAX_SEGMENTS)
)(
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 START,
   input  logic                 REACHED,
   input  logic [COORD_H_W-1:0] RAND_H,
   input  logic [COORD_V_W-1:0] RAND_V,
   input  logic [SEG_AW:0]      SNAKE_LENGTH,
   output logic [SEG_AW-1:0]    SEG_ADDR,
   input  logic [COORD_H_W-1:0] SEG_H,
   input  logic [COORD_V_W-1:0] SEG_V,
   output logic [COORD_H_W-1:0] TARGET_H,
   output logic [COORD_V_W-1:0] TARGET_V,
   output logic                 TARGET_VALID,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 FAIL,
   output logic [7:0]           TARGET_COUNT
);
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   place_state_t state, state_nx, retry;
   logic reached_q, restart, range_bad, reject, give_up, commit;
   logic scan_hit, scan_clear, scan_done;
   logic [COORD_H_W-1:0] cand_h;
   logic [COORD_V_W-1:0] cand_v;
   logic [SEG_AW:0] len;
   logic [TRY_W-1:0] tries;

   snake_body_scanner #(.SEG_AW(SEG_AW)) u_scan (
      .CLK(CLK), .RESET(RESET), .START(state == S_CHECK), .CMP(state == S_SCAN_CMP),
      .LEN(len), .CAND_H(cand_h), .CAND_V(cand_v), .SEG_H(SEG_H), .SEG_V(SEG_V),
      .SEG_ADDR(SEG_ADDR), .HIT(scan_hit), .CLEAR(scan_clear), .DONE(scan_done)
   );

   // START restarts from any state; a REACHED edge only counts when idle
   always_comb begin
      restart   = START || (state == S_IDLE && REACHED && !reached_q);
      range_bad = cand_h >= COORD_H_W'(H_MAX) || cand_v >= COORD_V_W'(V_MAX);
      reject    = (state == S_CHECK && range_bad) || scan_hit;
      give_up   = reject && tries == TRY_W'(MAX_TRIES) && !restart;
      commit    = state == S_COMMIT && !restart;
      retry     = tries == TRY_W'(MAX_TRIES) ? S_IDLE : S_SAMPLE;
      state_nx  = state;
      case (state)
         S_SAMPLE:    state_nx = S_CHECK;
         S_CHECK:     state_nx = range_bad ? retry : (len == '0 ? S_COMMIT : S_SCAN_ADDR);
         S_SCAN_ADDR: state_nx = S_SCAN_CMP;
         S_SCAN_CMP:  state_nx = scan_done ? (scan_clear ? S_COMMIT : retry) : S_SCAN_ADDR;
         S_COMMIT:    state_nx = S_IDLE;
         default:     state_nx = state;
      endcase
      if (restart) state_nx = S_SAMPLE;
      BUSY = state != S_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= S_IDLE;
         reached_q    <= 1'b1;
         cand_h       <= '0;
         cand_v       <= '0;
         len          <= '0;
         tries        <= '0;
         TARGET_H     <= '0;
         TARGET_V     <= '0;
         TARGET_VALID <= 1'b0;
         DONE         <= 1'b0;
         FAIL         <= 1'b0;
         TARGET_COUNT <= '0;
      end else begin
         state     <= state_nx;
         reached_q <= REACHED;
         DONE      <= commit;
         FAIL      <= give_up;
         if (restart) begin
            TARGET_VALID <= 1'b0;
            tries        <= '0;
         end else if (state == S_SAMPLE) begin
            cand_h <= RAND_H;
            cand_v <= RAND_V;
            len    <= SNAKE_LENGTH > (SEG_AW+1)'(MAX_SEGMENTS) ? (SEG_AW+1)'(MAX_SEGMENTS) : SNAKE_LENGTH;
            tries  <= tries + TRY_W'(1);
         end
         if (commit) begin
            TARGET_H     <= cand_h;
            TARGET_V     <= cand_v;
            TARGET_VALID <= 1'b1;
            TARGET_COUNT <= TARGET_COUNT + {7'd0, TARGET_COUNT != 8'hFF};
         end
      end
   end
endmodule

// File: tb/tb_target_placement_ctrl.sv
// tb_target_placement_ctrl: scoreboard bench; a cycle-level reference model predicts each
// placement outcome from the random-source history and body contents.
module tb_target_placement_ctrl;
   localparam int N = 40000;
   logic       CLK = 1'b0, RESET, START, REACHED;
   logic [7:0] RAND_H, SEG_H, TARGET_H, TARGET_COUNT;
   logic [6:0] RAND_V, SEG_V, TARGET_V;
   logic [5:0] SNAKE_LENGTH;
   logic [4:0] SEG_ADDR;
   logic       TARGET_VALID, BUSY, DONE, FAIL;

   typedef struct { bit fail; logic [7:0] h; logic [6:0] v; int at; } exp_t;
   exp_t q[$];
   logic [7:0] rh [N];
   logic [6:0] rv [N];
   logic [7:0] bh [32];
   logic [6:0] bv [32];
   int cyc = 0, checks = 0, errors = 0, exp_count = 0;

   target_placement_ctrl dut (
      .CLK(CLK), .RESET(RESET), .START(START), .REACHED(REACHED),
      .RAND_H(RAND_H), .RAND_V(RAND_V), .SNAKE_LENGTH(SNAKE_LENGTH),
      .SEG_ADDR(SEG_ADDR), .SEG_H(SEG_H), .SEG_V(SEG_V),
      .TARGET_H(TARGET_H), .TARGET_V(TARGET_V), .TARGET_VALID(TARGET_VALID),
      .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .TARGET_COUNT(TARGET_COUNT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   always @(posedge CLK) begin
      SEG_H <= bh[SEG_ADDR];
      SEG_V <= bv[SEG_ADDR];
   end
   always @(posedge CLK) begin
      #1;
      RAND_H = rh[cyc % N];
      RAND_V = rv[cyc % N];
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Walk the attempts: range reject costs 2 cycles, a hit at segment k costs 4+2k,
   // and an accepted candidate appears 3+2*len cycles after its sample cycle.
   function automatic exp_t predict(input int n, input int ln);
      exp_t e;
      int s, l, k;
      e = '{fail: 1'b1, h: 8'd0, v: 7'd0, at: 0};
      s = n + 1;
      l = ln > 32 ? 32 : ln;
      for (int t = 1; t <= 16; t++) begin
         k = -1;
         if (rh[s % N] < 160 && rv[s % N] < 120) begin
            for (int i = l - 1; i >= 0; i--)
               if (bh[i] == rh[s % N] && bv[i] == rv[s % N]) k = i;
            if (k < 0) begin
               e.fail = 1'b0;
               e.h    = rh[s % N];
               e.v    = rv[s % N];
               e.at   = s + 3 + 2 * l;
               return e;
            end
            e.at = s + 4 + 2 * k;
         end else e.at = s + 2;
         s = e.at;
      end
      return e;
   endfunction

   always @(negedge CLK) begin
      exp_t e;
      if (!RESET && (DONE || FAIL)) begin
         if (q.size() == 0) chk("unexpected_event", int'(DONE) + int'(FAIL), 0);
         else begin
            e = q.pop_front();
            chk("event_cycle", cyc, e.at);
            chk("fail_pulse", FAIL, e.fail);
            chk("done_pulse", DONE, !e.fail);
            chk("target_valid", TARGET_VALID, !e.fail);
            if (!e.fail) begin
               exp_count = exp_count == 255 ? 255 : exp_count + 1;
               chk("target_h", TARGET_H, e.h);
               chk("target_v", TARGET_V, e.v);
            end
            chk("target_count", TARGET_COUNT, exp_count);
         end
      end
   end

   task automatic tick(input int k = 1);
      repeat (k) @(posedge CLK);
      #1;
   endtask

   task automatic fill(input int from, input int cnt, input logic [7:0] h, input logic [6:0] v);
      for (int i = from; i < from + cnt; i++) begin
         rh[i % N] = h;
         rv[i % N] = v;
      end
   endtask

   task automatic fill_rand(input int from, input int cnt, input int l);
      int lm, idx;
      lm = l > 32 ? 32 : l;
      for (int i = from; i < from + cnt; i++) begin
         case ($urandom_range(0, 3))
            0: begin
               rh[i % N] = 8'($urandom_range(140, 255));
               rv[i % N] = 7'($urandom_range(100, 127));
            end
            1, 2: if (lm > 0) begin
               idx = $urandom_range(0, lm - 1);
               rh[i % N] = bh[idx];
               rv[i % N] = bv[idx];
            end else begin
               rh[i % N] = 8'($urandom_range(0, 159));
               rv[i % N] = 7'($urandom_range(0, 119));
            end
            default: begin
               rh[i % N] = 8'($urandom_range(0, 159));
               rv[i % N] = 7'($urandom_range(0, 119));
            end
         endcase
      end
   endtask

   task automatic trigger(input bit use_start);
      q.push_back(predict(cyc, SNAKE_LENGTH));
      if (use_start) START = 1'b1;
      else REACHED = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while ((q.size() != 0 || BUSY) && k < 3000) begin
         tick();
         k++;
      end
      chk({name, "_timeout"}, int'(k >= 3000), 0);
      if (k >= 3000) q.delete();
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_target_h"}, TARGET_H, 0);
      chk({name, "_target_v"}, TARGET_V, 0);
      chk({name, "_valid"}, TARGET_VALID, 0);
      chk({name, "_busy"}, BUSY, 0);
      chk({name, "_done"}, DONE, 0);
      chk({name, "_fail"}, FAIL, 0);
      chk({name, "_count"}, TARGET_COUNT, 0);
      chk({name, "_seg_addr"}, SEG_ADDR, 0);
   endtask

   task automatic new_body();
      for (int i = 0; i < 32; i++) begin
         bh[i] = 8'($urandom_range(0, 159));
         bv[i] = 7'($urandom_range(0, 119));
      end
   endtask

   initial begin
      int n, l;
      bit use_start;
      RESET = 1'b1; START = 1'b0; REACHED = 1'b0; SNAKE_LENGTH = '0;
      new_body();
      fill_rand(0, N, 0);
      tick(3);
      @(negedge CLK);
      chk_reset("reset");
      tick();
      RESET = 1'b0;
      tick(2);
      // first placement, empty body
      fill(cyc + 1, 50, 8'd10, 7'd20);
      trigger(1);
      wait_idle("s1");
      chk("s1_busy_after", BUSY, 0);
      chk("s1_valid_hold", TARGET_VALID, 1);
      // one range reject first
      fill(cyc + 1, 50, 8'd50, 7'd5);
      rh[(cyc + 1) % N] = 8'd200;
      trigger(1);
      wait_idle("s2");
      // collision on segment 1, then a clear candidate
      SNAKE_LENGTH = 6'd3;
      bh[0] = 8'd5;  bv[0] = 7'd5;
      bh[1] = 8'd10; bv[1] = 7'd20;
      bh[2] = 8'd7;  bv[2] = 7'd7;
      fill(cyc + 1, 80, 8'd11, 7'd20);
      rh[(cyc + 1) % N] = 8'd10;
      rv[(cyc + 1) % N] = 7'd20;
      trigger(1);
      wait_idle("s3");
      // every candidate out of range: give up
      fill(cyc + 1, 80, 8'd200, 7'd0);
      trigger(1);
      wait_idle("s4");
      chk("s4_valid", TARGET_VALID, 0);
      // REACHED held high for ten cycles
      SNAKE_LENGTH = '0;
      fill(cyc + 1, 50, 8'd33, 7'd44);
      trigger(0);
      tick(9);
      REACHED = 1'b0;
      wait_idle("s5");
      // REACHED high through reset release
      REACHED = 1'b1;
      RESET = 1'b1;
      q.delete();
      exp_count = 0;
      tick(2);
      RESET = 1'b0;
      tick(8);
      REACHED = 1'b0;
      tick(2);
      @(negedge CLK);
      chk("s5_reset_busy", BUSY, 0);
      chk("s5_reset_valid", TARGET_VALID, 0);
      chk("s5_reset_count", TARGET_COUNT, 0);
      tick();
      // reset while comparing the first segment
      SNAKE_LENGTH = 6'd5;
      for (int i = 0; i < 5; i++) begin
         bh[i] = 8'(i + 1);
         bv[i] = 7'd1;
      end
      fill(cyc + 1, 200, 8'd3, 7'd3);
      trigger(1);
      tick(3);
      RESET = 1'b1;
      q.delete();
      exp_count = 0;
      tick();
      @(negedge CLK);
      chk_reset("s6_midscan");
      tick();
      RESET = 1'b0;
      tick(2);
      // START during a scan restarts
      fill(cyc + 1, 100, 8'd3, 7'd3);
      trigger(1);
      tick(4);
      void'(q.pop_back());
      trigger(1);
      wait_idle("s6_scan_restart");
      // START during a reject streak must clear tries
      SNAKE_LENGTH = '0;
      n = cyc;
      fill(n + 1, 36, 8'd200, 7'd0);
      fill(n + 37, 40, 8'd60, 7'd60);
      trigger(1);
      tick(19);
      void'(q.pop_back());
      trigger(1);
      wait_idle("s6_tries_restart");
      // randomized placements, including clamp of long lengths and dropped busy edges
      for (int it = 0; it < 40; it++) begin
         l = $urandom_range(0, 40);
         SNAKE_LENGTH = 6'(l);
         new_body();
         fill_rand(cyc + 1, 1500, l);
         use_start = 1'($urandom_range(0, 1));
         REACHED = 1'b0;
         tick();
         trigger(use_start);
         if (!use_start) begin
            tick();
            REACHED = 1'b0;
            tick();
            REACHED = 1'b1;
         end
         wait_idle("rand");
         REACHED = 1'b0;
         tick();
      end
      tick(3);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
